// File: rtl/ota_offset_cal_if.sv
// ota_offset_cal_if: control/status bundle between the top level and the
// OTA offset calibration engine.
//   ena, start, man_load, man_code : requests into the engine
//   cmp_in                         : raw asynchronous OTA comparator output
//   trim_out, busy, done, cal_valid: registered engine outputs
// master = the side that drives requests (top level / bench),
// slave  = the calibration engine.
interface ota_offset_cal_if #(
  parameter int TRIM_W = 6
) ();
  logic              ena;
  logic              start;
  logic              cmp_in;
  logic              man_load;
  logic [TRIM_W-1:0] man_code;
  logic [TRIM_W-1:0] trim_out;
  logic              busy;
  logic              done;
  logic              cal_valid;

  modport master (
    output ena, start, cmp_in, man_load, man_code,
    input  trim_out, busy, done, cal_valid
  );

  modport slave (
    input  ena, start, cmp_in, man_load, man_code,
    output trim_out, busy, done, cal_valid
  );
endinterface

// File: rtl/ota_offset_cal.sv
// ota_offset_cal: successive-approximation offset trim search for the OTA.
// The OTA output (cmp_in, 1 = trim too high) is synchronized, then each trim
// bit from MSB to LSB is set, allowed to settle, and kept or cleared based on
// the comparator. A manual override loads man_code directly while idle.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : ota_offset_cal_if.slave (ena/start/cmp_in/man_load/man_code
//                in; trim_out/busy/done/cal_valid out, all registered)
// Build option: define OTA_CAL_AVG_EN to take three comparator samples per
// bit and decide by majority (rejects a single-cycle glitch).
module ota_offset_cal #(
  parameter int TRIM_W      = 6,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ota_offset_cal_if.slave bus
);
  localparam int BIT_W = $clog2(TRIM_W);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [TRIM_W-1:0] MID    = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(SETTLE_CYC - 1);

  // The synchronizer must have flushed a new trim's response before sampling.
  if (SETTLE_CYC < SYNC_STAGES) begin : g_bad_settle
    $error("SETTLE_CYC must be >= SYNC_STAGES");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t            state_q, state_n;
  logic [TRIM_W-1:0] trim_q, trim_n;
  logic [BIT_W-1:0]  bit_q, bit_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic              valid_q, valid_n;
  logic              done_q, done_n;
  logic              busy_q, busy_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              cmp_s;
  logic              decide, last;
`ifdef OTA_CAL_AVG_EN
  logic [1:0]        scnt_q, scnt_n;  // sample index within SAMPLE
  logic [1:0]        samp_q, samp_n;  // first two samples of the bit
`endif

  assign cmp_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.cmp_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      trim_q  <= MID;
      bit_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef OTA_CAL_AVG_EN
      scnt_q  <= '0;
      samp_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      trim_q  <= trim_n;
      bit_q   <= bit_n;
      cnt_q   <= cnt_n;
      valid_q <= valid_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
`ifdef OTA_CAL_AVG_EN
      scnt_q  <= scnt_n;
      samp_q  <= samp_n;
`endif
    end
  end

  always_comb begin
    state_n = state_q;
    trim_n  = trim_q;
    bit_n   = bit_q;
    cnt_n   = cnt_q;
    valid_n = valid_q;
    done_n  = 1'b0;
    decide  = 1'b0;
    last    = 1'b0;
`ifdef OTA_CAL_AVG_EN
    scnt_n  = scnt_q;
    samp_n  = samp_q;
`endif
    case (state_q)
      IDLE: begin
        // start has priority; a coincident man_code is dropped.
        if (bus.start && bus.ena) begin
          trim_n  = MID;
          bit_n   = BIT_W'(TRIM_W - 1);
          cnt_n   = RELOAD;
          valid_n = 1'b0;
          state_n = SETTLE;
        end else if (bus.man_load) begin
          trim_n  = bus.man_code;
          valid_n = 1'b0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_n = SAMPLE;
`ifdef OTA_CAL_AVG_EN
          scnt_n  = '0;
`endif
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      SAMPLE: begin
`ifdef OTA_CAL_AVG_EN
        if (scnt_q != 2'd2) begin
          samp_n = {samp_q[0], cmp_s};
          scnt_n = scnt_q + 1'b1;
        end else begin
          decide = (samp_q[1] & samp_q[0]) | (samp_q[1] & cmp_s) |
                   (samp_q[0] & cmp_s);
          last   = 1'b1;
        end
`else
        decide = cmp_s;
        last   = 1'b1;
`endif
        if (last) begin
          if (decide) trim_n[bit_q] = 1'b0;
          if (bit_q != '0) begin
            trim_n[bit_q - 1'b1] = 1'b1;
            bit_n   = bit_q - 1'b1;
            cnt_n   = RELOAD;
            state_n = SETTLE;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        valid_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Dropping ena aborts without a done pulse and parks the trim at midscale.
    if (!bus.ena && state_q != IDLE) begin
      state_n = IDLE;
      trim_n  = MID;
      valid_n = 1'b0;
      done_n  = 1'b0;
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.trim_out  = trim_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cal_valid = valid_q;
endmodule

// File: doc/ota_offset_cal.md
Name: ota_offset_cal

Overview:
Digital successive-approximation offset calibration engine for the on-chip OTA. It treats the OTA output as a comparator on cmp_in, which is analog-derived and asynchronous. It binary-searches a TRIM_W-bit offset trim code, which it drives to the OTA trim switches through the dedicated/bidir digital outputs. It also supports a manual trim override and reports busy, done and valid status to the top level.

Parameters:
TRIM_W, 6, trim code width in bits (2..8)
SETTLE_CYC, 16, clock cycles allowed for OTA settling after each trim change (must be >= SYNC_STAGES; elaboration error otherwise)
SYNC_STAGES, 2, flip-flop stages in the cmp_in synchronizer (2..3)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low aborts any calibration
start  input  1  calibration request, sampled on the clock edge
cmp_in  input  1  asynchronous OTA comparator output; 1 = trim code too high
man_load  input  1  manual trim load strobe
man_code  input  TRIM_W  manual trim value
trim_out  output  TRIM_W  trim code driven to the OTA
busy  output  1  calibration in progress
done  output  1  one-cycle pulse at calibration completion
cal_valid  output  1  trim_out holds a completed calibration result

Behaviour:
- Reset (async assert, synchronous release via the normal flop path):
  - trim_out = 1<<(TRIM_W-1), i.e. midscale.
  - busy = 0, done = 0, cal_valid = 0.
  - Synchronizer cleared to 0; FSM in IDLE.
- cmp_in passes through a SYNC_STAGES-deep synchronizer. Only its output cmp_s is used.
- FSM states: IDLE, SETTLE, SAMPLE, DONE. bit_idx counts down from TRIM_W-1; a settle counter counts down.
- IDLE:
  - start=1 and ena=1: trim_out <= MSB-only code (100..0), bit_idx <= TRIM_W-1, counter <= SETTLE_CYC-1, cal_valid <= 0, go to SETTLE.
  - Else, if man_load=1: trim_out <= man_code, cal_valid <= 0; stay in IDLE.
  - start and man_load asserted together: start wins and man_code is discarded.
- SETTLE: decrement the counter; go to SAMPLE in the cycle after the counter reads 0. SETTLE therefore lasts exactly SETTLE_CYC cycles.
- SAMPLE (1 cycle):
  - If cmp_s=1, clear trim_out[bit_idx].
  - If bit_idx > 0: set trim_out[bit_idx-1], decrement bit_idx, reload the counter, go to SETTLE.
  - If bit_idx = 0: go to DONE.
- DONE (1 cycle): done=1, cal_valid <= 1, then IDLE.
- busy = 1 in SETTLE, SAMPLE and DONE; busy = 0 in IDLE. All outputs are registered.
- Latency: with start accepted at edge 0, done is high for the cycle following edge 1 + TRIM_W*(SETTLE_CYC+1). Defaults give edge 103.
- start and man_load are ignored while busy; no queuing.
- ena low in any non-IDLE state: return to IDLE next edge, trim_out <= midscale, cal_valid <= 0, no done pulse.
- Reset mid-calibration: immediate return to reset values.
- The final code is the largest code c for which cmp was 0 at c. Comparator stuck at 1 gives 0; stuck at 0 gives all-ones. No wrap-around is possible.
- cal_valid stays set until the next accepted start, man_load, ena abort, or reset.

Optional Feature:
- Macro: OTA_CAL_AVG_EN.
- Defined:
  - SAMPLE lasts 3 cycles and takes cmp_s on each.
  - The bit decision is the majority of the 3 samples.
  - Latency becomes 1 + TRIM_W*(SETTLE_CYC+3) to done, i.e. 115 at defaults.
  - A single-cycle glitch in cmp_s during SAMPLE does not change the result.
- Undefined: single-sample SAMPLE exactly as described above.

Test Plan:
- Comparator model cmp_in = (trim_out > 37), defaults, start pulse: done at cycle 103, trim_out=37 (6'b100101), cal_valid=1, busy falls with done.
- cmp_in tied 1: final trim_out=0. cmp_in tied 0: final trim_out=63. Both at cycle 103.
- rst_n pulsed low at cycle 50 of a calibration: trim_out=32 immediately, busy=0, cal_valid=0, no done pulse. A new start then completes normally.
- In IDLE, man_load with man_code=21: trim_out=21 next cycle, cal_valid=0. man_load or start while busy: no effect on trim_out or timing.
- ena dropped for one cycle mid-calibration: trim_out returns to 32, busy=0, no done. start and man_load in the same cycle: calibration starts and trim_out=32 on the next edge.
- With OTA_CAL_AVG_EN and target 37: one-cycle cmp_in inversion during a SAMPLE still yields 37, with done at cycle 115.
